alu_rs_param: RTL and testbench
===============================

Name: alu_rs_param

Overview:
- Parametrised ALU reservation station; next generation of the fixed 64-entry ALU queue.
- Accepts up to 4 renamed ALU ops per cycle from dispatch and snoops NUM_FWD result-forwarding buses to capture missing operands.
- Issues up to 2 operand-complete ops per cycle to the two ALUs.
- New relative to the previous queue: real wakeup/select/free logic, a ready/credit handshake to dispatch, flush, and a same-cycle snoop on insert.

Parameters:
DEPTH, 16, number of entries (power of two, >=4)
DATA_W, 16, operand/result width
TAG_W, 6, ROB tag width
OP_W, 5, ALU opcode width
NUM_FWD, 4, number of forwarding buses

Ports:
clk  in  1  clock, all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous squash of all entries and issue outputs
fwd  in  NUM_FWD*(1+TAG_W+DATA_W)  per bus, bus k at slice k: {valid, tag, value}, MSB first
ins_valid  in  4  per-lane insert request
ins_op  in  4*OP_W  opcode, lane k at slice k
ins_rob  in  4*TAG_W  destination ROB tag
ins_tag_a / ins_tag_b  in  4*TAG_W  source tags, meaningful only when the matching rdy bit is 0
ins_val_a / ins_val_b  in  4*DATA_W  source values, meaningful only when the matching rdy bit is 1
ins_rdy_a / ins_rdy_b  in  4  operand already present
ins_ready  out  1  station can accept 4 ops this cycle
free_cnt  out  $clog2(DEPTH+1)  number of invalid entries
iss_valid  out  2  issue lane valid (registered)
iss_op  out  2*OP_W  issued opcode (registered)
iss_rob  out  2*TAG_W  issued ROB tag (registered)
iss_val_a / iss_val_b  out  2*DATA_W  issued operands (registered)

Behaviour:
- Entry state: valid, op, rob, tag_a/b, val_a/b, rdy_a/b.
- Reset (rst_n=0, asynchronous): all entry valid=0; all iss_* = 0. After reset free_cnt=DEPTH and ins_ready=1.
- free_cnt: combinational popcount of invalid entries in current state. ins_ready = (free_cnt >= 4). Both depend only on registered state, never on same-cycle issue.
- Insert:
  - When ins_ready=1, each lane with ins_valid=1 is written at the edge.
  - Valid lanes go in ascending lane order into free entries in ascending index order; lane gaps are allowed.
  - When ins_ready=0, all lanes are ignored. Dispatch must hold them; there is no partial accept.
- Snoop on insert: an inserted operand with rdy=0 whose tag matches a valid fwd bus in the same cycle is written with rdy=1 and the bus value.
- Wakeup:
  - Each cycle, every valid entry with rdy_x=0 compares tag_x to every valid fwd bus.
  - On a match it captures the value and sets rdy_x=1 at the edge.
  - If several buses match, the lowest bus index wins.
  - Operands A and B are independent; both may wake in the same cycle from the same or different buses.
- Select:
  - Candidates: entries with valid & rdy_a & rdy_b in the current state.
  - The lowest-index candidate goes to issue lane 0 and the next lowest to lane 1.
  - At the edge, the selected entries clear valid and iss_* registers load their fields. iss_valid bits are set per selected entry, otherwise 0.
  - With a single candidate: lane 1 iss_valid=0 and its data is don't-care.
- Latencies:
  - Insert with both rdy=1 at edge E0 gives iss_valid at E1.
  - Forward at cycle t (capturing edge t) gives issue at edge t+1.
  - Snoop-on-insert behaves the same as a normal wakeup.
- Freed slots count toward free_cnt one cycle after issue. Insert and issue in the same edge never touch the same entry.
- The ALUs always accept; there is no issue backpressure.
- flush=1 at an edge:
  - Clears every entry valid and iss_valid.
  - Drops that cycle's inserts; fwd captures are irrelevant.
  - Takes priority over insert, wakeup and select.
- Tags and ROB values are opaque: equality compare only, no wrap arithmetic.

Test Plan:
- Reset then insert 4 ops with all rdy=1, values A=k, B=10+k, rob=k -> next cycle iss lanes carry rob 0,1; cycle after carry rob 2,3; free_cnt returns to 16.
- Insert op rob=5 with rdy_a=0, tag_a=9 -> nothing issues; drive fwd bus 2 {1,9,0x1234} -> the cycle after capture issues rob 5 with val_a=0x1234.
- Same cycle as insert, drive fwd {1,tag_a,0xBEEF} -> captured on insert, issued at the next edge with val_a=0xBEEF.
- Fill to 13 valid entries with pending operands -> free_cnt=3, ins_ready=0, and an asserted insert is ignored (free_cnt unchanged). One issue then brings free_cnt to 4 and ins_ready=1.
- Buses 0 and 3 both carry tag 7 with values 0x1111/0x2222 -> the waiting entry captures 0x1111.
- Pending entries plus issue in flight, flush=1 -> next cycle iss_valid=0 and free_cnt=16. Asserting rst_n=0 mid-operation clears iss_valid immediately (before the next clock edge).

Source files
------------

// File: rtl/alu_rs_param_if.sv
// alu_rs_param_if: dispatch / forwarding / issue bundle of the ALU reservation
// station.
//   fwd        NUM_FWD result-forwarding buses, bus k at slice k: {valid, tag, value}
//   ins_*      four dispatch insert lanes, lane k at slice k
//   ins_ready  station can take four ops this cycle
//   free_cnt   number of invalid entries
//   iss_*      two registered issue lanes towards the ALUs
// The master modport belongs to the dispatch/forwarding side and the slave
// modport to the station.
interface alu_rs_param_if #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned OP_W    = 5,
  parameter int unsigned NUM_FWD = 4
);
  localparam int unsigned FWD_W = 1 + TAG_W + DATA_W;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [NUM_FWD*FWD_W-1:0] fwd;
  logic [3:0]               ins_valid;
  logic [4*OP_W-1:0]        ins_op;
  logic [4*TAG_W-1:0]       ins_rob;
  logic [4*TAG_W-1:0]       ins_tag_a;
  logic [4*TAG_W-1:0]       ins_tag_b;
  logic [4*DATA_W-1:0]      ins_val_a;
  logic [4*DATA_W-1:0]      ins_val_b;
  logic [3:0]               ins_rdy_a;
  logic [3:0]               ins_rdy_b;
  logic                     ins_ready;
  logic [CNT_W-1:0]         free_cnt;
  logic [1:0]               iss_valid;
  logic [2*OP_W-1:0]        iss_op;
  logic [2*TAG_W-1:0]       iss_rob;
  logic [2*DATA_W-1:0]      iss_val_a;
  logic [2*DATA_W-1:0]      iss_val_b;

  modport master (
    output fwd, ins_valid, ins_op, ins_rob, ins_tag_a, ins_tag_b,
           ins_val_a, ins_val_b, ins_rdy_a, ins_rdy_b,
    input  ins_ready, free_cnt, iss_valid, iss_op, iss_rob, iss_val_a, iss_val_b
  );

  modport slave (
    input  fwd, ins_valid, ins_op, ins_rob, ins_tag_a, ins_tag_b,
           ins_val_a, ins_val_b, ins_rdy_a, ins_rdy_b,
    output ins_ready, free_cnt, iss_valid, iss_op, iss_rob, iss_val_a, iss_val_b
  );
endinterface

// File: rtl/alu_rs_param.sv
// alu_rs_param: parametrised ALU reservation station.
// Takes up to four renamed ops per cycle, wakes pending operands from NUM_FWD
// forwarding buses (including on the insert cycle itself) and issues up to two
// operand-complete ops per cycle, lowest entry index first.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears entries and issue registers)
//   flush  synchronous squash of all entries and issue lanes
//   bus    alu_rs_param_if slave: insert lanes, forwarding buses, issue lanes
module alu_rs_param #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned OP_W    = 5,
  parameter int unsigned NUM_FWD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  alu_rs_param_if.slave bus
);
  localparam int unsigned FWD_W = 1 + TAG_W + DATA_W;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned LANES = 4;

  // Entry storage
  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0]             rdy_a_q, rdy_a_d;
  logic [DEPTH-1:0]             rdy_b_q, rdy_b_d;
  logic [DEPTH-1:0][OP_W-1:0]   op_q, op_d;
  logic [DEPTH-1:0][TAG_W-1:0]  rob_q, rob_d;
  logic [DEPTH-1:0][TAG_W-1:0]  tag_a_q, tag_a_d;
  logic [DEPTH-1:0][TAG_W-1:0]  tag_b_q, tag_b_d;
  logic [DEPTH-1:0][DATA_W-1:0] val_a_q, val_a_d;
  logic [DEPTH-1:0][DATA_W-1:0] val_b_q, val_b_d;

  // Issue registers, lane 0 in the low slice
  logic [1:0]              iss_valid_q;
  logic [1:0][OP_W-1:0]    iss_op_q;
  logic [1:0][TAG_W-1:0]   iss_rob_q;
  logic [1:0][DATA_W-1:0]  iss_val_a_q;
  logic [1:0][DATA_W-1:0]  iss_val_b_q;

  logic [CNT_W-1:0] free_cnt;
  logic             ins_ready;
  logic [DEPTH-1:0] cand;
  logic             hit0, hit1;
  logic [IDX_W-1:0] sel0, sel1;
  logic [DEPTH-1:0] taken;
  logic             placed;
  logic [DATA_W:0]  wake_a, wake_b;

  // Returns {hit, value}. Scanning from the highest bus down lets the
  // lowest-index matching bus overwrite last, so it wins.
  function automatic logic [DATA_W:0] fwd_lookup(
    input logic [TAG_W-1:0]         tag,
    input logic [NUM_FWD*FWD_W-1:0] fwd
  );
    logic [DATA_W:0] res;
    logic [FWD_W-1:0] slot;
    res = '0;
    for (int unsigned k = NUM_FWD; k > 0; k--) begin
      slot = fwd[(k-1)*FWD_W +: FWD_W];
      if (slot[FWD_W-1] && (slot[DATA_W +: TAG_W] == tag)) begin
        res = {1'b1, slot[DATA_W-1:0]};
      end
    end
    return res;
  endfunction

  // Occupancy: registered state only, never the same-cycle issue.
  always_comb begin
    free_cnt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!valid_q[i]) free_cnt = free_cnt + CNT_W'(1);
    end
  end

  assign ins_ready = (free_cnt >= CNT_W'(LANES));

  // Select: two lowest-index operand-complete entries
  always_comb begin
    cand = valid_q & rdy_a_q & rdy_b_q;
    hit0 = 1'b0;
    hit1 = 1'b0;
    sel0 = '0;
    sel1 = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (cand[i]) begin
        if (!hit0) begin
          hit0 = 1'b1;
          sel0 = IDX_W'(i);
        end else if (!hit1) begin
          hit1 = 1'b1;
          sel1 = IDX_W'(i);
        end
      end
    end
  end

  // Entry next state: wakeup, then select frees, then insert into entries that
  // are invalid now (so never a selected one), and flush overrides everything.
  always_comb begin
    valid_d = valid_q;
    rdy_a_d = rdy_a_q;
    rdy_b_d = rdy_b_q;
    op_d    = op_q;
    rob_d   = rob_q;
    tag_a_d = tag_a_q;
    tag_b_d = tag_b_q;
    val_a_d = val_a_q;
    val_b_d = val_b_q;
    taken   = '0;
    placed  = 1'b0;
    wake_a  = '0;
    wake_b  = '0;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      wake_a = fwd_lookup(tag_a_q[i], bus.fwd);
      wake_b = fwd_lookup(tag_b_q[i], bus.fwd);
      if (valid_q[i] && !rdy_a_q[i] && wake_a[DATA_W]) begin
        rdy_a_d[i] = 1'b1;
        val_a_d[i] = wake_a[DATA_W-1:0];
      end
      if (valid_q[i] && !rdy_b_q[i] && wake_b[DATA_W]) begin
        rdy_b_d[i] = 1'b1;
        val_b_d[i] = wake_b[DATA_W-1:0];
      end
    end

    if (hit0) valid_d[sel0] = 1'b0;
    if (hit1) valid_d[sel1] = 1'b0;

    if (ins_ready) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        placed = 1'b0;
        if (bus.ins_valid[l]) begin
          wake_a = fwd_lookup(bus.ins_tag_a[l*TAG_W +: TAG_W], bus.fwd);
          wake_b = fwd_lookup(bus.ins_tag_b[l*TAG_W +: TAG_W], bus.fwd);
          for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!placed && !valid_q[i] && !taken[i]) begin
              placed     = 1'b1;
              taken[i]   = 1'b1;
              valid_d[i] = 1'b1;
              op_d[i]    = bus.ins_op[l*OP_W +: OP_W];
              rob_d[i]   = bus.ins_rob[l*TAG_W +: TAG_W];
              tag_a_d[i] = bus.ins_tag_a[l*TAG_W +: TAG_W];
              tag_b_d[i] = bus.ins_tag_b[l*TAG_W +: TAG_W];
              if (bus.ins_rdy_a[l]) begin
                rdy_a_d[i] = 1'b1;
                val_a_d[i] = bus.ins_val_a[l*DATA_W +: DATA_W];
              end else begin
                rdy_a_d[i] = wake_a[DATA_W];
                val_a_d[i] = wake_a[DATA_W-1:0];
              end
              if (bus.ins_rdy_b[l]) begin
                rdy_b_d[i] = 1'b1;
                val_b_d[i] = bus.ins_val_b[l*DATA_W +: DATA_W];
              end else begin
                rdy_b_d[i] = wake_b[DATA_W];
                val_b_d[i] = wake_b[DATA_W-1:0];
              end
            end
          end
        end
      end
    end

    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload is only meaningful while valid is set, so it carries no reset.
  always_ff @(posedge clk) begin
    rdy_a_q <= rdy_a_d;
    rdy_b_q <= rdy_b_d;
    op_q    <= op_d;
    rob_q   <= rob_d;
    tag_a_q <= tag_a_d;
    tag_b_q <= tag_b_d;
    val_a_q <= val_a_d;
    val_b_q <= val_b_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_q <= '0;
      iss_op_q    <= '0;
      iss_rob_q   <= '0;
      iss_val_a_q <= '0;
      iss_val_b_q <= '0;
    end else if (flush) begin
      iss_valid_q <= '0;
    end else begin
      iss_valid_q <= {hit1, hit0};
      if (hit0) begin
        iss_op_q[0]    <= op_q[sel0];
        iss_rob_q[0]   <= rob_q[sel0];
        iss_val_a_q[0] <= val_a_q[sel0];
        iss_val_b_q[0] <= val_b_q[sel0];
      end
      if (hit1) begin
        iss_op_q[1]    <= op_q[sel1];
        iss_rob_q[1]   <= rob_q[sel1];
        iss_val_a_q[1] <= val_a_q[sel1];
        iss_val_b_q[1] <= val_b_q[sel1];
      end
    end
  end

  assign bus.ins_ready = ins_ready;
  assign bus.free_cnt  = free_cnt;
  assign bus.iss_valid = iss_valid_q;
  assign bus.iss_op    = iss_op_q;
  assign bus.iss_rob   = iss_rob_q;
  assign bus.iss_val_a = iss_val_a_q;
  assign bus.iss_val_b = iss_val_b_q;
endmodule

// File: tb/tb_alu_rs_param.sv
module tb_alu_rs_param;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned TAG_W   = 6;
  localparam int unsigned OP_W    = 5;
  localparam int unsigned NUM_FWD = 4;
  localparam int unsigned FWD_W   = 1 + TAG_W + DATA_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
  int   vectors = 0;
  int   errors  = 0;

  alu_rs_param_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W), .NUM_FWD(NUM_FWD)) bus ();

  alu_rs_param #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W), .NUM_FWD(NUM_FWD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [TAG_W-1:0] rob_of(input int l);
    return bus.iss_rob[l*TAG_W +: TAG_W];
  endfunction
  function automatic logic [DATA_W-1:0] va_of(input int l);
    return bus.iss_val_a[l*DATA_W +: DATA_W];
  endfunction
  function automatic logic [DATA_W-1:0] vb_of(input int l);
    return bus.iss_val_b[l*DATA_W +: DATA_W];
  endfunction
  function automatic logic [OP_W-1:0] op_of(input int l);
    return bus.iss_op[l*OP_W +: OP_W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.fwd       = '0;
    bus.ins_valid = '0;
    bus.ins_op    = '0;
    bus.ins_rob   = '0;
    bus.ins_tag_a = '0;
    bus.ins_tag_b = '0;
    bus.ins_val_a = '0;
    bus.ins_val_b = '0;
    bus.ins_rdy_a = '0;
    bus.ins_rdy_b = '0;
    flush         = 1'b0;
  endtask

  // Opcode is rob ^ 5'h15 so the op field carries a recognisable value.
  task automatic set_lane(input int l, input logic [TAG_W-1:0] rob,
                          input logic ra, input logic [TAG_W-1:0] ta, input logic [DATA_W-1:0] va,
                          input logic rb, input logic [TAG_W-1:0] tb, input logic [DATA_W-1:0] vb);
    bus.ins_valid[l]                  = 1'b1;
    bus.ins_op[l*OP_W +: OP_W]        = rob[OP_W-1:0] ^ 5'h15;
    bus.ins_rob[l*TAG_W +: TAG_W]     = rob;
    bus.ins_rdy_a[l]                  = ra;
    bus.ins_tag_a[l*TAG_W +: TAG_W]   = ta;
    bus.ins_val_a[l*DATA_W +: DATA_W] = va;
    bus.ins_rdy_b[l]                  = rb;
    bus.ins_tag_b[l*TAG_W +: TAG_W]   = tb;
    bus.ins_val_b[l*DATA_W +: DATA_W] = vb;
  endtask

  task automatic set_fwd(input int k, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] val);
    bus.fwd[k*FWD_W +: FWD_W] = {1'b1, tag, val};
  endtask

  task automatic test_reset();
    clear_inputs();
    #1 rst_n = 1'b0;
    #1;
    vectors++; if (bus.iss_valid !== 2'b00) begin errors++; $display("FAIL reset_iss_valid: got %b expected 00", bus.iss_valid); end
    vectors++; if (bus.free_cnt !== 5'd16) begin errors++; $display("FAIL reset_free_cnt: got %0d expected 16", bus.free_cnt); end
    vectors++; if (bus.ins_ready !== 1'b1) begin errors++; $display("FAIL reset_ins_ready: got %b expected 1", bus.ins_ready); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_insert_issue();
    for (int k = 0; k < 4; k++)
      set_lane(k, TAG_W'(k), 1'b1, '0, DATA_W'(k), 1'b1, '0, DATA_W'(10 + k));
    tick();
    clear_inputs();
    vectors++; if (bus.iss_valid !== 2'b00) begin errors++; $display("FAIL ins_no_early_issue: got %b expected 00", bus.iss_valid); end
    vectors++; if (bus.free_cnt !== 5'd12) begin errors++; $display("FAIL ins_free_after_insert: got %0d expected 12", bus.free_cnt); end
    tick();
    vectors++; if (bus.iss_valid !== 2'b11) begin errors++; $display("FAIL ins_issue1_valid: got %b expected 11", bus.iss_valid); end
    vectors++; if (rob_of(0) !== 6'd0 || rob_of(1) !== 6'd1) begin errors++; $display("FAIL ins_issue1_rob: got %0d,%0d expected 0,1", rob_of(0), rob_of(1)); end
    vectors++; if (op_of(0) !== 5'h15 || op_of(1) !== 5'h14) begin errors++; $display("FAIL ins_issue1_op: got %h,%h expected 15,14", op_of(0), op_of(1)); end
    vectors++; if (va_of(1) !== 16'd1 || vb_of(1) !== 16'd11) begin errors++; $display("FAIL ins_issue1_vals: got %0d,%0d expected 1,11", va_of(1), vb_of(1)); end
    vectors++; if (bus.free_cnt !== 5'd14) begin errors++; $display("FAIL ins_free_after_issue1: got %0d expected 14", bus.free_cnt); end
    tick();
    vectors++; if (bus.iss_valid !== 2'b11) begin errors++; $display("FAIL ins_issue2_valid: got %b expected 11", bus.iss_valid); end
    vectors++; if (rob_of(0) !== 6'd2 || rob_of(1) !== 6'd3) begin errors++; $display("FAIL ins_issue2_rob: got %0d,%0d expected 2,3", rob_of(0), rob_of(1)); end
    vectors++; if (va_of(0) !== 16'd2 || vb_of(1) !== 16'd13) begin errors++; $display("FAIL ins_issue2_vals: got %0d,%0d expected 2,13", va_of(0), vb_of(1)); end
    vectors++; if (bus.free_cnt !== 5'd16) begin errors++; $display("FAIL ins_free_restored: got %0d expected 16", bus.free_cnt); end
    tick();
    vectors++; if (bus.iss_valid !== 2'b00) begin errors++; $display("FAIL ins_idle: got %b expected 00", bus.iss_valid); end
  endtask

  task automatic test_wakeup();
    set_lane(0, 6'd5, 1'b0, 6'd9, '0, 1'b1, '0, 16'h0055);
    tick();
    clear_inputs();
    tick();
    vectors++; if (bus.iss_valid !== 2'b00) begin errors++; $display("FAIL wake_pending_hold: got %b expected 00", bus.iss_valid); end
    set_fwd(2, 6'd9, 16'h1234);
    tick();
    clear_inputs();
    vectors++; if (bus.iss_valid !== 2'b00) begin errors++; $display("FAIL wake_capture_edge: got %b expected 00", bus.iss_valid); end
    tick();
    vectors++; if (bus.iss_valid !== 2'b01) begin errors++; $display("FAIL wake_issue_valid: got %b expected 01", bus.iss_valid); end
    vectors++; if (rob_of(0) !== 6'd5) begin errors++; $display("FAIL wake_issue_rob: got %0d expected 5", rob_of(0)); end
    vectors++; if (va_of(0) !== 16'h1234 || vb_of(0) !== 16'h0055) begin errors++; $display("FAIL wake_issue_vals: got %h,%h expected 1234,0055", va_of(0), vb_of(0)); end
    vectors++; if (bus.free_cnt !== 5'd16) begin errors++; $display("FAIL wake_free: got %0d expected 16", bus.free_cnt); end
  endtask

  task automatic test_snoop_insert();
    set_lane(1, 6'd6, 1'b0, 6'd12, '0, 1'b1, '0, 16'd7);
    set_fwd(0, 6'd12, 16'hBEEF);
    tick();
    clear_inputs();
    vectors++; if (bus.iss_valid !== 2'b00) begin errors++; $display("FAIL snoop_insert_edge: got %b expected 00", bus.iss_valid); end
    tick();
    vectors++; if (bus.iss_valid !== 2'b01 || rob_of(0) !== 6'd6) begin errors++; $display("FAIL snoop_issue: got valid %b rob %0d expected 01 rob 6", bus.iss_valid, rob_of(0)); end
    vectors++; if (va_of(0) !== 16'hBEEF) begin errors++; $display("FAIL snoop_val_a: got %h expected BEEF", va_of(0)); end
  endtask

  task automatic test_priority();
    set_lane(0, 6'd8, 1'b0, 6'd7, '0, 1'b0, 6'd7, '0);
    tick();
    clear_inputs();
    set_fwd(0, 6'd7, 16'h1111);
    set_fwd(3, 6'd7, 16'h2222);
    tick();
    clear_inputs();
    vectors++; if (bus.iss_valid !== 2'b00) begin errors++; $display("FAIL prio_capture_edge: got %b expected 00", bus.iss_valid); end
    tick();
    vectors++; if (bus.iss_valid !== 2'b01 || rob_of(0) !== 6'd8) begin errors++; $display("FAIL prio_issue: got valid %b rob %0d expected 01 rob 8", bus.iss_valid, rob_of(0)); end
    vectors++; if (va_of(0) !== 16'h1111 || vb_of(0) !== 16'h1111) begin errors++; $display("FAIL prio_lowest_bus: got %h,%h expected 1111,1111", va_of(0), vb_of(0)); end
  endtask

  // Leaves robs 21..32 pending in entries 1..12, A tags 31..42.
  task automatic test_full();
    for (int b = 0; b < 4; b++) begin
      for (int l = 0; l < ((b < 3) ? 4 : 1); l++)
        set_lane(l, TAG_W'(20 + b*4 + l), 1'b0, TAG_W'(30 + b*4 + l), '0, 1'b1, '0, DATA_W'(100 + b*4 + l));
      tick();
      clear_inputs();
    end
    vectors++; if (bus.free_cnt !== 5'd3) begin errors++; $display("FAIL full_free_cnt: got %0d expected 3", bus.free_cnt); end
    vectors++; if (bus.ins_ready !== 1'b0) begin errors++; $display("FAIL full_ins_ready: got %b expected 0", bus.ins_ready); end
    for (int k = 0; k < 4; k++)
      set_lane(k, TAG_W'(50 + k), 1'b1, '0, '0, 1'b1, '0, '0);
    tick();
    clear_inputs();
    vectors++; if (bus.free_cnt !== 5'd3) begin errors++; $display("FAIL full_insert_ignored: got %0d expected 3", bus.free_cnt); end
    set_fwd(0, 6'd30, 16'h0C0C);
    tick();
    clear_inputs();
    vectors++; if (bus.iss_valid !== 2'b00) begin errors++; $display("FAIL full_no_issue_of_ignored: got %b expected 00", bus.iss_valid); end
    tick();
    vectors++; if (bus.iss_valid !== 2'b01 || rob_of(0) !== 6'd20) begin errors++; $display("FAIL full_issue: got valid %b rob %0d expected 01 rob 20", bus.iss_valid, rob_of(0)); end
    vectors++; if (bus.free_cnt !== 5'd4) begin errors++; $display("FAIL full_free_after_issue: got %0d expected 4", bus.free_cnt); end
    vectors++; if (bus.ins_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_issue: got %b expected 1", bus.ins_ready); end
  endtask

  task automatic test_flush();
    set_fwd(0, 6'd31, 16'h0AAA);
    set_fwd(1, 6'd32, 16'h0BBB);
    tick();
    clear_inputs();
    set_fwd(0, 6'd33, 16'h0CCC);
    tick();
    clear_inputs();
    vectors++; if (bus.iss_valid !== 2'b11) begin errors++; $display("FAIL flush_pre_valid: got %b expected 11", bus.iss_valid); end
    vectors++; if (rob_of(0) !== 6'd21 || rob_of(1) !== 6'd22 || va_of(0) !== 16'h0AAA) begin errors++; $display("FAIL flush_pre_issue: got rob %0d,%0d val %h expected 21,22 val 0AAA", rob_of(0), rob_of(1), va_of(0)); end
    vectors++; if (bus.free_cnt !== 5'd6) begin errors++; $display("FAIL flush_pre_free: got %0d expected 6", bus.free_cnt); end
    for (int k = 0; k < 4; k++)
      set_lane(k, TAG_W'(40 + k), 1'b1, '0, '0, 1'b1, '0, '0);
    flush = 1'b1;
    tick();
    clear_inputs();
    vectors++; if (bus.iss_valid !== 2'b00) begin errors++; $display("FAIL flush_iss_valid: got %b expected 00", bus.iss_valid); end
    vectors++; if (bus.free_cnt !== 5'd16) begin errors++; $display("FAIL flush_free_cnt: got %0d expected 16", bus.free_cnt); end
    tick();
    vectors++; if (bus.iss_valid !== 2'b00) begin errors++; $display("FAIL flush_inserts_dropped: got %b expected 00", bus.iss_valid); end
  endtask

  task automatic test_async_reset();
    set_lane(0, 6'd60, 1'b1, '0, 16'd1, 1'b1, '0, 16'd2);
    set_lane(2, 6'd61, 1'b1, '0, 16'd3, 1'b1, '0, 16'd4);
    tick();
    clear_inputs();
    tick();
    vectors++; if (bus.iss_valid !== 2'b11 || rob_of(1) !== 6'd61) begin errors++; $display("FAIL arst_pre_issue: got valid %b rob1 %0d expected 11 rob1 61", bus.iss_valid, rob_of(1)); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (bus.iss_valid !== 2'b00) begin errors++; $display("FAIL arst_iss_valid: got %b expected 00", bus.iss_valid); end
    vectors++; if (bus.free_cnt !== 5'd16) begin errors++; $display("FAIL arst_free_cnt: got %0d expected 16", bus.free_cnt); end
    #1 rst_n = 1'b1;
    tick();
    vectors++; if (bus.iss_valid !== 2'b00 || bus.ins_ready !== 1'b1) begin errors++; $display("FAIL arst_post: got valid %b ready %b expected 00 1", bus.iss_valid, bus.ins_ready); end
  endtask

  initial begin
    test_reset();
    test_insert_issue();
    test_wakeup();
    test_snoop_insert();
    test_priority();
    test_full();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
